// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// ==  Module   : regfile_write_arbiter                                      ==
// ==  Purpose  : Shares the single register-file write port between        ==
// ==             NUM_REQ writeback requesters (ALU, load unit, PC/link).    ==
// ==             Round-robin arbitration over valid/ready handshakes; the   ==
// ==             winning beat is registered onto the regfile write port.    ==
// ==             An optional lock keeps the grant with one requester for    ==
// ==             multi-register bursts (LDM, pops).                         ==
// ==  Config   : RF_ARB_LOCK_EN - when defined, req_lock is honoured and    ==
// ==             the LOCKED state is reachable. When undefined, req_lock    ==
// ==             is ignored and the arbiter is pure round-robin.            ==
// ==  Ports    : clk            - clock, all state updates on posedge       ==
// ==             reset          - synchronous, active-high                  ==
// ==             req_valid      - [NUM_REQ] write pending per requester     ==
// ==             req_lock       - [NUM_REQ] keep grant after this beat      ==
// ==             req_addr       - [NUM_REQ*ADDR_WIDTH] packed reg indices   ==
// ==             req_data       - [NUM_REQ*WORD_SIZE] packed write data     ==
// ==             req_ready      - [NUM_REQ] one-hot or zero, combinational  ==
// ==             rf_write_en    - registered regfile write enable           ==
// ==             rf_write_reg   - registered regfile write address          ==
// ==             rf_write_data  - registered regfile write data             ==
// ==             grant_id       - requester that produced current beat      ==
// ==  Revision : 1.0 - initial release                                      ==
// ============================================================================
module regfile_write_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 3,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rf_write_en,
    output logic [ADDR_WIDTH-1:0]         rf_write_reg,
    output logic [WORD_SIZE-1:0]          rf_write_data,
    output logic [IDW-1:0]                grant_id
);

    // Index of the highest-numbered requester; the round-robin pointer
    // wraps to zero after it.
    localparam logic [IDW-1:0] c_last_idx = IDW'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [IDW-1:0]        r_rr_ptr;
    logic [IDW-1:0]        r_lock_owner;
    logic                  r_write_en;
    logic [ADDR_WIDTH-1:0] r_write_reg;
    logic [WORD_SIZE-1:0]  r_write_data;
    logic [IDW-1:0]        r_grant_id;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [NUM_REQ-1:0]    w_ready;
    logic [IDW-1:0]        w_grant_idx;
    logic                  w_found;
    logic                  w_accept;
    logic [IDW-1:0]        w_next_ptr;
    logic [NUM_REQ-1:0]    w_lock_eff;
    logic [ADDR_WIDTH-1:0] w_addr [NUM_REQ];
    logic [WORD_SIZE-1:0]  w_data [NUM_REQ];

    // Unpack the flat request buses so the winner can be selected by index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_data[gi] = req_data[gi*WORD_SIZE  +: WORD_SIZE];
    end

    // Lock requests only matter when the burst feature is built in. In the
    // plain round-robin build the port is kept for a uniform interface but
    // its value never reaches the state machine.
`ifdef RF_ARB_LOCK_EN
    assign w_lock_eff = req_lock;
`else
    logic w_unused_lock;
    assign w_lock_eff    = '0;
    assign w_unused_lock = ^req_lock;
`endif

    // ------------------------------------------------------------------
    // Grant selection. Depends only on state, pointer and valids so that
    // ready never has a path from the address/data buses. Ready is forced
    // low while reset is held so no beat can be consumed during reset.
    // ------------------------------------------------------------------
    always_comb begin
        int j;
        j           = 0;
        w_ready     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        if (!reset) begin
            if (r_state == ST_LOCKED) begin
                // Only the lock owner may proceed; everybody else stalls
                // even when the owner has nothing to send this cycle.
                w_grant_idx = r_lock_owner;
                if (req_valid[r_lock_owner]) begin
                    w_ready[r_lock_owner] = 1'b1;
                    w_found               = 1'b1;
                end
            end else begin
                // Search rr_ptr, rr_ptr+1, ... with wrap; first valid wins.
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = int'(r_rr_ptr) + k;
                    if (j >= NUM_REQ) begin
                        j = j - NUM_REQ;
                    end
                    if (!w_found && req_valid[j]) begin
                        w_found      = 1'b1;
                        w_ready[j]   = 1'b1;
                        w_grant_idx  = IDW'(j);
                    end
                end
            end
        end
    end

    assign w_accept = |(w_ready & req_valid);

    // Pointer moves just past whoever finished; when leaving LOCKED the
    // winner is the lock owner, so the same expression covers both cases.
    assign w_next_ptr = (w_grant_idx == c_last_idx) ? '0 : (w_grant_idx + IDW'(1));

    // ------------------------------------------------------------------
    // State machine and registered write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_ARB;
            r_rr_ptr     <= '0;
            r_lock_owner <= '0;
            r_write_en   <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_grant_id   <= '0;
        end else begin
            // One write per accepted beat; address/data hold otherwise.
            r_write_en <= w_accept;
            if (w_accept) begin
                r_write_reg  <= w_addr[w_grant_idx];
                r_write_data <= w_data[w_grant_idx];
                r_grant_id   <= w_grant_idx;
                if (w_lock_eff[w_grant_idx]) begin
                    // Entering or staying in a burst; the pointer is left
                    // alone so fairness resumes from where it was.
                    r_lock_owner <= w_grant_idx;
                    r_state      <= ST_LOCKED;
                end else begin
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= ST_ARB;
                end
            end
        end
    end

    assign req_ready     = w_ready;
    assign rf_write_en   = r_write_en;
    assign rf_write_reg  = r_write_reg;
    assign rf_write_data = r_write_data;
    assign grant_id      = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// ==  Module   : tb_regfile_write_arbiter                                   ==
// ==  Purpose  : Directed, table-driven bench for regfile_write_arbiter     ==
// ==             with hand-written reset and burst sequences. Expected      ==
// ==             grants follow the round-robin / lock rules; expected       ==
// ==             write address and data come from the stimulus the bench   ==
// ==             itself drives. Works with and without RF_ARB_LOCK_EN.      ==
// ==  Revision : 1.0 - initial release                                      ==
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int WORD_SIZE  = 32;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REQ    = 3;
    localparam int IDW        = 2;

    logic                          clk;
    logic                          reset;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WORD_SIZE-1:0]  req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rf_write_en;
    logic [ADDR_WIDTH-1:0]         rf_write_reg;
    logic [WORD_SIZE-1:0]          rf_write_data;
    logic [IDW-1:0]                grant_id;

    regfile_write_arbiter #(
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REQ    (NUM_REQ)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_lock      (req_lock),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_write_en   (rf_write_en),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .grant_id      (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected write-port contents; they hold across idle cycles.
    logic [ADDR_WIDTH-1:0] exp_reg  = '0;
    logic [WORD_SIZE-1:0]  exp_data = '0;
    logic [IDW-1:0]        exp_gid  = '0;

    typedef struct packed {
        logic               rst;
        logic [NUM_REQ-1:0] v;
        logic [NUM_REQ-1:0] l;
        logic [NUM_REQ-1:0] er;
        logic               ew;
        logic [IDW-1:0]     eg;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic [2:0] v, input logic [2:0] l,
                       input logic [2:0] er, input logic ew, input logic [1:0] eg);
        vec_t t;
        t.rst = rst; t.v = v; t.l = l; t.er = er; t.ew = ew; t.eg = eg;
        vecs.push_back(t);
    endtask

    // Distinct address/data per requester and step so a wrong mux select
    // shows up; addresses sweep all 16 registers including 15.
    task automatic set_pattern(input int st);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = 4'(st + i*6);
            req_data[i*WORD_SIZE  +: WORD_SIZE]  = {4'(i+1), 12'hABC, 16'(st)};
        end
    endtask

    // Drive one cycle of inputs, check ready before the edge and the
    // registered write port just after it.
    task automatic apply(input logic rst, input logic [2:0] v, input logic [2:0] l,
                         input logic [2:0] er, input logic ew, input logic [1:0] eg,
                         input string nm);
        reset     = rst;
        req_valid = v;
        req_lock  = l;
        #1;
        chk({nm, " ready"}, 32'(req_ready), 32'(er));
        if (rst) begin
            exp_reg  = '0;
            exp_data = '0;
            exp_gid  = '0;
        end else if (ew) begin
            exp_reg  = req_addr[int'(eg)*ADDR_WIDTH +: ADDR_WIDTH];
            exp_data = req_data[int'(eg)*WORD_SIZE  +: WORD_SIZE];
            exp_gid  = eg;
        end
        @(posedge clk);
        #1;
        chk({nm, " wen"},  32'(rf_write_en),  32'(ew && !rst));
        chk({nm, " reg"},  32'(rf_write_reg), 32'(exp_reg));
        chk({nm, " data"}, rf_write_data,     exp_data);
        chk({nm, " gid"},  32'(grant_id),     32'(exp_gid));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        st        = 0;
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset held with every requester valid: nothing may be accepted.
        for (int c = 0; c < 3; c++) begin
            set_pattern(st); st++;
            apply(1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 2'd0, "reset_hold");
        end

        // Continuous contention from reset: 0,1,2,0,1,2 without gaps.
        add(0, 3'b111, 3'b000, 3'b001, 1, 2'd0);
        add(0, 3'b111, 3'b000, 3'b010, 1, 2'd1);
        add(0, 3'b111, 3'b000, 3'b100, 1, 2'd2);
        add(0, 3'b111, 3'b000, 3'b001, 1, 2'd0);
        add(0, 3'b111, 3'b000, 3'b010, 1, 2'd1);
        add(0, 3'b111, 3'b000, 3'b100, 1, 2'd2);
        // Idle: no write, address/data hold.
        add(0, 3'b000, 3'b000, 3'b000, 0, 2'd0);
        // Partial valids exercise the wrap of the search (rr 0->2->1->0->2).
        add(0, 3'b010, 3'b000, 3'b010, 1, 2'd1);
        add(0, 3'b011, 3'b000, 3'b001, 1, 2'd0);
        add(0, 3'b101, 3'b000, 3'b100, 1, 2'd2);
        add(0, 3'b010, 3'b000, 3'b010, 1, 2'd1);
`ifdef RF_ARB_LOCK_EN
        // Req 2 burst lock=1,1,1,0 with a one-cycle valid gap; 0/1 stall.
        add(0, 3'b111, 3'b100, 3'b100, 1, 2'd2);
        add(0, 3'b111, 3'b100, 3'b100, 1, 2'd2);
        add(0, 3'b011, 3'b100, 3'b000, 0, 2'd0);
        add(0, 3'b111, 3'b100, 3'b100, 1, 2'd2);
        add(0, 3'b111, 3'b000, 3'b100, 1, 2'd2);
        add(0, 3'b111, 3'b000, 3'b001, 1, 2'd0);
`else
        // Same stimulus, lock ignored: plain rotation.
        add(0, 3'b111, 3'b100, 3'b100, 1, 2'd2);
        add(0, 3'b111, 3'b100, 3'b001, 1, 2'd0);
        add(0, 3'b011, 3'b100, 3'b010, 1, 2'd1);
        add(0, 3'b111, 3'b100, 3'b100, 1, 2'd2);
        add(0, 3'b111, 3'b000, 3'b001, 1, 2'd0);
        add(0, 3'b111, 3'b000, 3'b010, 1, 2'd1);
`endif

        foreach (vecs[k]) begin
            set_pattern(st); st++;
            apply(vecs[k].rst, vecs[k].v, vecs[k].l, vecs[k].er, vecs[k].ew,
                  vecs[k].eg, $sformatf("vec%0d", k));
        end

        // Lone requester 1 with a fixed write.
        set_pattern(st); st++;
        req_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 4'h3;
        req_data[1*WORD_SIZE  +: WORD_SIZE]  = 32'hDEADBEEF;
        apply(1'b0, 3'b010, 3'b000, 3'b010, 1'b1, 2'd1, "single_req1");
        chk("single_req1 fixed reg",  32'(rf_write_reg), 32'h3);
        chk("single_req1 fixed data", rf_write_data,     32'hDEADBEEF);

        // Reset while req 1 holds the lock: lock dropped, req 0 wins after.
        set_pattern(st); st++;
        apply(1'b0, 3'b010, 3'b010, 3'b010, 1'b1, 2'd1, "lock_req1");
        set_pattern(st); st++;
`ifdef RF_ARB_LOCK_EN
        apply(1'b0, 3'b101, 3'b000, 3'b000, 1'b0, 2'd0, "locked_stall");
`else
        apply(1'b0, 3'b101, 3'b000, 3'b100, 1'b1, 2'd2, "no_lock_rr");
`endif
        set_pattern(st); st++;
        apply(1'b1, 3'b111, 3'b010, 3'b000, 1'b0, 2'd0, "reset_mid_burst");
        set_pattern(st); st++;
        apply(1'b0, 3'b111, 3'b000, 3'b001, 1'b1, 2'd0, "after_reset");
        set_pattern(st); st++;
        apply(1'b0, 3'b111, 3'b000, 3'b010, 1'b1, 2'd1, "after_reset2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
